seg_display_mux: RTL and testbench

Time-multiplexed driver for the stopwatch's 4-digit common-anode 7-segment display. It consumes the four 5-bit digit values produced by the stopwatch counter (min_l, min_r, sec_l, sec_r) and scans them onto shared segment lines with per-digit anode strobes. It also blinks the digit currently selected for adjustment. It sits between the counter and the board pins.

---
 rtl/stopwatch_pkg.sv | 36 +++
 rtl/seg_display_mux_if.sv | 22 ++
 rtl/seg_display_mux_decoder.sv | 14 +
 rtl/seg_display_mux.sv | 88 ++++++++
 tb/tb_seg_display_mux.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: active-low 7-segment glyphs, display digit
// positions and the adjust-select encoding used by the counter and the display.
package stopwatch_pkg;

    // Bit order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDX_SEC_R = 2'd0,
        IDX_SEC_L = 2'd1,
        IDX_MIN_R = 2'd2,
        IDX_MIN_L = 2'd3
    } digit_idx_e;

    localparam logic [2:0] ADJ_MIN_L = 3'd0;
    localparam logic [2:0] ADJ_MIN_R = 3'd1;
    localparam logic [2:0] ADJ_SEC_L = 3'd2;
    localparam logic [2:0] ADJ_SEC_R = 3'd3;

    // True when the adjust selection refers to the digit at display position idx.
    function automatic logic adj_hits(input logic [2:0] adj_sel, input digit_idx_e idx);
        case (adj_sel)
            ADJ_MIN_L: return idx == IDX_MIN_L;
            ADJ_MIN_R: return idx == IDX_MIN_R;
            ADJ_SEC_L: return idx == IDX_SEC_L;
            ADJ_SEC_R: return idx == IDX_SEC_R;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// Counter-to-display bundle: digit values and adjust state in, pin drive out.
interface seg_display_mux_if;
    logic [4:0] min_l;
    logic [4:0] min_r;
    logic [4:0] sec_l;
    logic [4:0] sec_r;
    logic       adj_mode;
    logic [2:0] adj_sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (
        output min_l, min_r, sec_l, sec_r, adj_mode, adj_sel,
        input  seg, dp, an
    );

    modport slave (
        input  min_l, min_r, sec_l, sec_r, adj_mode, adj_sel,
        output seg, dp, an
    );
endinterface

// File: rtl/seg_display_mux_decoder.sv
// Combinational 5-bit digit value to active-low 7-segment pattern; 10..31 show a dash.
module seg_decoder
    import stopwatch_pkg::*;
(
    input  logic [4:0] value,
    output logic [6:0] pattern
);
    always_comb begin
        pattern = SEG_DASH;
        for (int i = 0; i < 10; i++) begin
            if (value == 5'(i)) pattern = SEG_DIGIT[i];
        end
    end
endmodule

// File: rtl/seg_display_mux.sv
// 4-digit common-anode scan driver with per-frame input snapshot, anti-ghost
// dead time, colon on the minutes-ones digit and blinking of the adjusted digit.
module seg_display_mux
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input logic              clk,
    input logic              rst_n,
    seg_display_mux_if.slave bus
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_cnt;
    digit_idx_e    digit_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [4:0]    shadow [4];
    logic [4:0]    cur_val;
    logic [6:0]    glyph;
    logic          blanked;
    logic [3:0]    an_next;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    assign cur_val = shadow[digit_idx];

    seg_decoder u_decoder (
        .value   (cur_val),
        .pattern (glyph)
    );

    // First cycle of each slot is dead time; a blinked digit stays dark for its whole slot.
    always_comb begin
        blanked = bus.adj_mode && blink_phase && adj_hits(bus.adj_sel, digit_idx);
        an_next = 4'b1111;
        if (refresh_cnt != '0 && !blanked) an_next[digit_idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= IDX_SEC_R;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            if (refresh_cnt == REFRESH_LAST) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx_e'(digit_idx + 2'd1);
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            // Whole-frame snapshot so one scan never mixes old and new digits.
            if (refresh_cnt == '0 && digit_idx == IDX_SEC_R) begin
                shadow[IDX_SEC_R] <= bus.sec_r;
                shadow[IDX_SEC_L] <= bus.sec_l;
                shadow[IDX_MIN_R] <= bus.min_r;
                shadow[IDX_MIN_L] <= bus.min_l;
            end

            an_q  <= an_next;
            seg_q <= glyph;
            dp_q  <= an_next[IDX_MIN_R];
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with REFRESH_DIV = 4, BLINK_DIV = 32.
module tb_seg_display_mux;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg_display_mux_if bus ();

    seg_display_mux #(.REFRESH_DIV(4), .BLINK_DIV(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n = 0;

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic goto_edge(input int k);
        while (edge_n < k) step();
    endtask

    task automatic set_digits(input logic [4:0] ml, input logic [4:0] mr,
                              input logic [4:0] sl, input logic [4:0] sr);
        bus.min_l = ml;
        bus.min_r = mr;
        bus.sec_l = sl;
        bus.sec_r = sr;
    endtask

    // Assert reset between clock edges; returns while reset is held.
    task automatic hold_reset();
        #2;
        rst_n = 1'b0;
        #1;
    endtask

    // Release on a falling edge; the next rising edge is edge 1.
    task automatic release_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        set_digits(5'd1, 5'd2, 5'd3, 5'd4);
        bus.adj_mode = 1'b0;
        bus.adj_sel  = 3'd7;
        release_reset();
        goto_edge(7);
        n_cmp++;
        if (bus.an !== 4'b1101) begin
            n_fail++; $display("FAIL reset_pre_an got %b want %b", bus.an, 4'b1101);
        end
        hold_reset();
        n_cmp++;
        if (bus.an !== 4'b1111) begin
            n_fail++; $display("FAIL reset_async_an got %b want %b", bus.an, 4'b1111);
        end
        n_cmp++;
        if (bus.seg !== 7'h7F) begin
            n_fail++; $display("FAIL reset_async_seg got %h want %h", bus.seg, 7'h7F);
        end
        n_cmp++;
        if (bus.dp !== 1'b1) begin
            n_fail++; $display("FAIL reset_async_dp got %b want %b", bus.dp, 1'b1);
        end
        release_reset();
        goto_edge(1);
        n_cmp++;
        if (bus.an !== 4'b1111) begin
            n_fail++; $display("FAIL reset_edge1_an got %b want %b", bus.an, 4'b1111);
        end
        for (int k = 2; k <= 4; k++) begin
            goto_edge(k);
            n_cmp++;
            if (bus.an !== 4'b1110) begin
                n_fail++; $display("FAIL reset_edge%0d_an got %b want %b", k, bus.an, 4'b1110);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] an_exp  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] seg_exp [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        logic       dp_exp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        set_digits(5'd1, 5'd2, 5'd3, 5'd4);
        bus.adj_mode = 1'b0;
        hold_reset();
        release_reset();
        for (int s = 0; s < 4; s++) begin
            goto_edge(4 * s + 1);
            n_cmp++;
            if (bus.an !== 4'b1111) begin
                n_fail++; $display("FAIL scan_dead%0d an got %b want %b", s, bus.an, 4'b1111);
            end
            for (int p = 2; p <= 4; p++) begin
                goto_edge(4 * s + p);
                n_cmp++;
                if (bus.an !== an_exp[s] || bus.seg !== seg_exp[s] || bus.dp !== dp_exp[s]) begin
                    n_fail++;
                    $display("FAIL scan_slot%0d_c%0d an/seg/dp got %b/%b/%b want %b/%b/%b",
                             s, p, bus.an, bus.seg, bus.dp, an_exp[s], seg_exp[s], dp_exp[s]);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        set_digits(5'd1, 5'd2, 5'd3, 5'd4);
        hold_reset();
        release_reset();
        goto_edge(2);
        n_cmp++;
        if (bus.seg !== 7'b0011001) begin
            n_fail++; $display("FAIL snap_f1_sec_r seg got %b want %b", bus.seg, 7'b0011001);
        end
        goto_edge(3);
        bus.sec_l = 5'd12;
        goto_edge(6);
        n_cmp++;
        if (bus.an !== 4'b1101 || bus.seg !== 7'b0110000) begin
            n_fail++; $display("FAIL snap_f1_sec_l an/seg got %b/%b want %b/%b",
                               bus.an, bus.seg, 4'b1101, 7'b0110000);
        end
        goto_edge(10);
        bus.sec_r = 5'd9;
        goto_edge(18);
        n_cmp++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'b0010000) begin
            n_fail++; $display("FAIL snap_f2_sec_r an/seg got %b/%b want %b/%b",
                               bus.an, bus.seg, 4'b1110, 7'b0010000);
        end
        goto_edge(22);
        n_cmp++;
        if (bus.an !== 4'b1101 || bus.seg !== 7'b0111111) begin
            n_fail++; $display("FAIL snap_f2_sec_l an/seg got %b/%b want %b/%b",
                               bus.an, bus.seg, 4'b1101, 7'b0111111);
        end
    endtask

    task automatic test_out_of_range();
        set_digits(5'd31, 5'd10, 5'd12, 5'd0);
        hold_reset();
        release_reset();
        goto_edge(2);
        n_cmp++;
        if (bus.seg !== 7'b1000000) begin
            n_fail++; $display("FAIL oor_zero seg got %b want %b", bus.seg, 7'b1000000);
        end
        for (int s = 1; s < 4; s++) begin
            goto_edge(4 * s + 2);
            n_cmp++;
            if (bus.seg !== 7'b0111111) begin
                n_fail++; $display("FAIL oor_slot%0d seg got %b want %b", s, bus.seg, 7'b0111111);
            end
        end
    endtask

    task automatic test_blink();
        int         edges  [7] = '{14, 16, 34, 46, 48, 62, 78};
        logic [3:0] an_exp [7] = '{4'b0111, 4'b0111, 4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b0111};
        set_digits(5'd1, 5'd2, 5'd3, 5'd4);
        bus.adj_mode = 1'b1;
        bus.adj_sel  = 3'd0;
        hold_reset();
        release_reset();
        for (int i = 0; i < 7; i++) begin
            goto_edge(edges[i]);
            n_cmp++;
            if (bus.an !== an_exp[i]) begin
                n_fail++; $display("FAIL blink_sel0_e%0d an got %b want %b", edges[i], bus.an, an_exp[i]);
            end
        end
        bus.adj_sel = 3'd1;
        goto_edge(90);
        n_cmp++;
        if (bus.an !== 4'b1011 || bus.dp !== 1'b0) begin
            n_fail++; $display("FAIL blink_sel1_on an/dp got %b/%b want %b/%b", bus.an, bus.dp, 4'b1011, 1'b0);
        end
        goto_edge(106);
        n_cmp++;
        if (bus.an !== 4'b1111 || bus.dp !== 1'b1) begin
            n_fail++; $display("FAIL blink_sel1_off an/dp got %b/%b want %b/%b", bus.an, bus.dp, 4'b1111, 1'b1);
        end
        goto_edge(110);
        n_cmp++;
        if (bus.an !== 4'b0111) begin
            n_fail++; $display("FAIL blink_sel1_other an got %b want %b", bus.an, 4'b0111);
        end
        bus.adj_sel = 3'd5;
        goto_edge(122);
        n_cmp++;
        if (bus.an !== 4'b1011 || bus.dp !== 1'b0) begin
            n_fail++; $display("FAIL blink_sel5_e122 an/dp got %b/%b want %b/%b", bus.an, bus.dp, 4'b1011, 1'b0);
        end
        goto_edge(126);
        n_cmp++;
        if (bus.an !== 4'b0111) begin
            n_fail++; $display("FAIL blink_sel5_e126 an got %b want %b", bus.an, 4'b0111);
        end
        bus.adj_mode = 1'b0;
        bus.adj_sel  = 3'd0;
        goto_edge(174);
        n_cmp++;
        if (bus.an !== 4'b0111) begin
            n_fail++; $display("FAIL blink_mode_off an got %b want %b", bus.an, 4'b0111);
        end
        bus.adj_mode = 1'b1;
        bus.adj_sel  = 3'd3;
        goto_edge(178);
        n_cmp++;
        if (bus.an !== 4'b1111) begin
            n_fail++; $display("FAIL blink_sel3 an got %b want %b", bus.an, 4'b1111);
        end
        bus.adj_mode = 1'b0;
        bus.adj_sel  = 3'd7;
    endtask

    task automatic test_mid_frame_reset();
        logic [6:0] seg_exp [4] = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
        set_digits(5'd1, 5'd2, 5'd3, 5'd4);
        hold_reset();
        release_reset();
        goto_edge(11);
        n_cmp++;
        if (bus.an !== 4'b1011 || bus.seg !== 7'b0100100 || bus.dp !== 1'b0) begin
            n_fail++; $display("FAIL mid_pre an/seg/dp got %b/%b/%b want %b/%b/%b",
                               bus.an, bus.seg, bus.dp, 4'b1011, 7'b0100100, 1'b0);
        end
        set_digits(5'd5, 5'd6, 5'd7, 5'd8);
        hold_reset();
        n_cmp++;
        if (bus.an !== 4'b1111 || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
            n_fail++; $display("FAIL mid_blank an/seg/dp got %b/%h/%b want %b/%h/%b",
                               bus.an, bus.seg, bus.dp, 4'b1111, 7'h7F, 1'b1);
        end
        release_reset();
        goto_edge(1);
        n_cmp++;
        if (bus.an !== 4'b1111) begin
            n_fail++; $display("FAIL mid_edge1 an got %b want %b", bus.an, 4'b1111);
        end
        for (int s = 0; s < 4; s++) begin
            goto_edge(4 * s + 2);
            n_cmp++;
            if (bus.seg !== seg_exp[s]) begin
                n_fail++; $display("FAIL mid_slot%0d seg got %b want %b", s, bus.seg, seg_exp[s]);
            end
        end
        n_cmp++;
        if (bus.an !== 4'b0111) begin
            n_fail++; $display("FAIL mid_slot3 an got %b want %b", bus.an, 4'b0111);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_out_of_range();
        test_blink();
        test_mid_frame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
